// File: rtl/pixel_seq_pkg.sv
// pixel_seq_pkg: state encoding, default parameters and Gray helper for the pixel frame sequencer
package pixel_seq_pkg;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_READ_SETTLE,
        ST_READ_HOLD,
        ST_DONE
    } seq_state_e;
    localparam int ADC_W_DEF         = 8;
    localparam int ERASE_CYCLES_DEF  = 5;
    localparam int SETTLE_CYCLES_DEF = 3;
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction
endpackage

// File: rtl/ramp_counter.sv
// ramp_counter: clear/enable ramp counter with registered code output (Gray-coded when GRAY_COUNT_EN is defined)
//   clk_i, rst_i : clock, synchronous active-high reset
//   clr_i        : force count to 0 (priority over en_i)
//   en_i         : advance count by one
//   code_o       : registered ramp code (binary, or Gray of the count under GRAY_COUNT_EN)
module ramp_counter import pixel_seq_pkg::*; #(
    parameter int ADC_W = ADC_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [ADC_W-1:0] code_o
);
    logic [ADC_W-1:0] cnt_q, cnt_d, code_q, code_d;
    always_comb begin
        cnt_d = clr_i ? '0 : en_i ? cnt_q + ADC_W'(1) : cnt_q;
`ifdef GRAY_COUNT_EN
        code_d = ADC_W'(bin2gray(32'(cnt_d)));
`else
        code_d = cnt_d;
`endif
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            code_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            code_q <= code_d;
        end
    end
    assign code_o = code_q;
endmodule

// File: rtl/pixel_frame_sequencer.sv
// pixel_frame_sequencer: sequences erase/expose/ramp-convert/row-readout of one pixel-array frame
//   CLK, RESET          : clock, synchronous active-high reset
//   START, EXPOSE_CYCLES: frame start (IDLE only) and exposure length latched at start (0 acts as 1)
//   ERASE/EXPOSE/CONVERT/READ : mutually exclusive phase strobes, READ one-hot per row
//   ADC_CODE            : ramp code (Gray-coded when GRAY_COUNT_EN is defined)
//   PIXEL_DATA          : row data from the array, captured on the last settle cycle
//   OUT_DATA/OUT_ROW/OUT_VALID/OUT_READY : captured row handed downstream over valid/ready
//   BUSY, FRAME_DONE    : not-idle flag and one-cycle end-of-frame pulse
module pixel_frame_sequencer import pixel_seq_pkg::*; #(
    parameter int NROWS         = 2,
    parameter int ADC_W         = ADC_W_DEF,
    parameter int ERASE_CYCLES  = ERASE_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [15:0]      EXPOSE_CYCLES,
    output logic             ERASE,
    output logic             EXPOSE,
    output logic             CONVERT,
    output logic [NROWS-1:0] READ,
    output logic [ADC_W-1:0] ADC_CODE,
    input  logic [15:0]      PIXEL_DATA,
    output logic [15:0]      OUT_DATA,
    output logic [2:0]       OUT_ROW,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic             BUSY,
    output logic             FRAME_DONE
);
    // phase counter must hold both a 16-bit exposure and a full ramp length
    localparam int CW = (ADC_W > 16) ? ADC_W : 16;
    localparam logic [CW-1:0] CONV_LAST   = CW'((64'd1 << ADC_W) - 64'd1);
    localparam logic [CW-1:0] ERASE_LAST  = CW'(ERASE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    seq_state_e  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0] exp_q, exp_d;
    logic [2:0]  row_q, row_d;
    logic [15:0] out_data_q;
    logic [2:0]  out_row_q;
    logic        busy_q;
    logic        last;
    logic        capture;
    assign last    = cnt_q == '0;
    assign capture = (state_q == ST_READ_SETTLE) && last;
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            exp_q      <= '0;
            row_q      <= '0;
            out_data_q <= '0;
            out_row_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            row_q      <= row_d;
            out_data_q <= capture ? PIXEL_DATA : out_data_q;
            out_row_q  <= capture ? row_q : out_row_q;
            busy_q     <= state_d != ST_IDLE;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = last ? cnt_q : cnt_q - CW'(1);
        exp_d   = exp_q;
        row_d   = row_q;
        case (state_q)
            ST_IDLE: if (START) begin
                state_d = ST_ERASE;
                cnt_d   = ERASE_LAST;
                exp_d   = (EXPOSE_CYCLES == '0) ? 16'd1 : EXPOSE_CYCLES;
                row_d   = '0;
            end
            ST_ERASE: if (last) begin
                state_d = ST_EXPOSE;
                cnt_d   = CW'(exp_q - 16'd1);
            end
            ST_EXPOSE: if (last) begin
                state_d = ST_CONVERT;
                cnt_d   = CONV_LAST;
            end
            ST_CONVERT: if (last) begin
                state_d = ST_READ_SETTLE;
                cnt_d   = SETTLE_LAST;
                row_d   = '0;
            end
            ST_READ_SETTLE: if (last) state_d = ST_READ_HOLD;
            ST_READ_HOLD: if (OUT_READY) begin
                state_d = (row_q == 3'(NROWS - 1)) ? ST_DONE : ST_READ_SETTLE;
                cnt_d   = SETTLE_LAST;
                row_d   = (row_q == 3'(NROWS - 1)) ? row_q : row_q + 3'd1;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end
    always_comb begin
        ERASE      = state_q == ST_ERASE;
        EXPOSE     = state_q == ST_EXPOSE;
        CONVERT    = state_q == ST_CONVERT;
        READ       = (state_q == ST_READ_SETTLE) ? NROWS'(1) << row_q : '0;
        OUT_VALID  = state_q == ST_READ_HOLD;
        FRAME_DONE = state_q == ST_DONE;
        OUT_DATA   = out_data_q;
        OUT_ROW    = out_row_q;
        BUSY       = busy_q;
    end
    // the last ramp step is not taken so ADC_CODE holds the final code after CONVERT
    ramp_counter #(.ADC_W(ADC_W)) u_ramp (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .clr_i  ((state_q == ST_IDLE) && START),
        .en_i   ((state_q == ST_CONVERT) && !last),
        .code_o (ADC_CODE)
    );
endmodule
